// File: rtl/lut_sweep_pkg.sv
// Shared types and width helpers for the lut_sweep block.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of one per-output minterm counter (must hold the value 2^n_in).
  function automatic int unsigned cnt_w(input int unsigned n_in);
    return n_in + 1;
  endfunction

  // Width of the table-select port; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n_out);
    int unsigned w;
    w = $clog2(n_out);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lut_eval.sv
// Combinational lookup of N_OUT truth tables at a single index.
module lut_eval #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 4
) (
  input  logic [N_OUT*(2**N_IN)-1:0] tables,
  input  logic [N_IN-1:0]            idx,
  output logic [N_OUT-1:0]           res_c
);

  localparam int unsigned T = 2**N_IN;

  // Output j is bit idx of table j.
  always_comb begin
    res_c = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      res_c[j] = tables[j*T + 32'(idx)];
    end
  end

endmodule

// File: rtl/lut_sweep.sv
// Programmable N_IN->N_OUT truth-table block with an exhaustive-sweep engine.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [sel_w(N_OUT)-1:0]           cfg_sel,
  input  logic [(2**N_IN)-1:0]              cfg_data,
  input  logic [N_IN-1:0]                   x,
  output logic [N_OUT-1:0]                  y,
  input  logic                              start,
  output logic                              busy,
  output logic                              sweep_valid,
  output logic [N_IN-1:0]                   sweep_idx,
  output logic [N_OUT-1:0]                  sweep_y,
  output logic                              done,
  output logic [N_OUT*cnt_w(N_IN)-1:0]      ones_cnt
);

  localparam int unsigned T  = 2**N_IN;
  localparam int unsigned CW = cnt_w(N_IN);

  logic [N_OUT*T-1:0] tables;
  logic [N_IN-1:0]    idx;
  state_t             state;
  logic [N_OUT-1:0]   direct_res;
  logic [N_OUT-1:0]   sweep_res;
  logic               accept;

  // Config and start are honoured only when fully idle (busy also covers the done cycle).
  assign accept = (state == IDLE) && !busy;

  lut_eval #(.N_IN(N_IN), .N_OUT(N_OUT)) u_eval_direct (
    .tables (tables),
    .idx    (x),
    .res_c  (direct_res)
  );

  lut_eval #(.N_IN(N_IN), .N_OUT(N_OUT)) u_eval_sweep (
    .tables (tables),
    .idx    (idx),
    .res_c  (sweep_res)
  );

  // Truth-table storage; out-of-range selects are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tables <= '0;
    end else if (cfg_we && accept && (32'(cfg_sel) < N_OUT)) begin
      tables[32'(cfg_sel)*T +: T] <= cfg_data;
    end
  end

  // Registered direct evaluation, live in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= direct_res;
    end
  end

  // Sweep sequencer with registered status, stream and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_idx   <= '0;
      sweep_y     <= '0;
      done        <= 1'b0;
      ones_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sweep_valid <= 1'b0;
          busy        <= 1'b0;
          if (start && accept) begin
            state    <= SWEEP;
            idx      <= '0;
            ones_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_valid <= 1'b1;
          sweep_idx   <= idx;
          sweep_y     <= sweep_res;
          for (int unsigned j = 0; j < N_OUT; j++) begin
            ones_cnt[j*CW +: CW] <= ones_cnt[j*CW +: CW] + CW'(sweep_res[j]);
          end
          if (idx == N_IN'(T-1)) begin
            state <= DONE;
          end else begin
            idx <= idx + N_IN'(1);
          end
        end
        DONE: begin
          sweep_valid <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep.sv
// Directed self-checking bench for lut_sweep (N_IN=3, N_OUT=4, plus an N_OUT=5 instance).
module tb_lut_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance: N_IN=3, N_OUT=4
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_data = '0;
  logic [2:0]  x = '0;
  logic [3:0]  y;
  logic        start = 1'b0;
  logic        busy, sweep_valid, done;
  logic [2:0]  sweep_idx;
  logic [3:0]  sweep_y;
  logic [15:0] ones_cnt;

  // Second instance: N_OUT=5 so that a 3-bit select can be out of range
  logic        cfg_we2 = 1'b0;
  logic [2:0]  cfg_sel2 = '0;
  logic [7:0]  cfg_data2 = '0;
  logic [2:0]  x2 = '0;
  logic [4:0]  y2;
  logic        start2 = 1'b0;
  logic        busy2, sweep_valid2, done2;
  logic [2:0]  sweep_idx2;
  logic [4:0]  sweep_y2;
  logic [19:0] ones_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lut_sweep #(.N_IN(3), .N_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .x(x), .y(y), .start(start), .busy(busy), .sweep_valid(sweep_valid),
    .sweep_idx(sweep_idx), .sweep_y(sweep_y), .done(done), .ones_cnt(ones_cnt)
  );

  lut_sweep #(.N_IN(3), .N_OUT(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_sel(cfg_sel2), .cfg_data(cfg_data2),
    .x(x2), .y(y2), .start(start2), .busy(busy2), .sweep_valid(sweep_valid2),
    .sweep_idx(sweep_idx2), .sweep_y(sweep_y2), .done(done2), .ones_cnt(ones_cnt2)
  );

  // Expected sweep_y per index for f=E8, a=96, b=80, c=FE (y = {c,b,a,f}).
  logic [3:0] exp_tab [8] = '{4'h0, 4'hA, 4'hA, 4'h9, 4'hA, 4'h9, 4'h9, 4'hF};
  logic [3:0] exp_zero [8] = '{default: 4'h0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Full sweep on the main instance; optionally pokes cfg_we/start mid-sweep.
  task automatic run_sweep(input logic [3:0] expy [8], input logic [15:0] expcnt,
                           input bit poke, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    check({tag, " valid_low_at_start"}, 32'(sweep_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 2) begin
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'h00; start = 1'b1;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
      check($sformatf("%s valid[%0d]", tag, i), 32'(sweep_valid), 32'd1);
      check($sformatf("%s idx[%0d]", tag, i), 32'(sweep_idx), 32'(i));
      check($sformatf("%s sweep_y[%0d]", tag, i), 32'(sweep_y), 32'(expy[i]));
      check($sformatf("%s done_low[%0d]", tag, i), 32'(done), 32'd0);
    end
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd1);
    check({tag, " valid_drop"}, 32'(sweep_valid), 32'd0);
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, " done_end"}, 32'(done), 32'd0);
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    check({tag, " ones_cnt"}, 32'(ones_cnt), 32'(expcnt));
    check({tag, " sweep_y_hold"}, 32'(sweep_y), 32'(expy[7]));
  endtask

  initial begin
    // Load tables in reset-release window, then re-reset with tables loaded.
    tick();
    rst_n = 1'b1;
    tick();
    load(2'd0, 8'hE8);
    load(2'd1, 8'h96);
    load(2'd2, 8'h80);
    load(2'd3, 8'hFE);
    x = 3'b011;
    tick();
    check("y_before_reset", 32'(y), 32'h9);

    // Async reset clears everything including tables.
    rst_n = 1'b0;
    #1;
    check("rst y", 32'(y), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst ones_cnt", 32'(ones_cnt), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst tables cleared", 32'(y), 32'h0);

    // Reload and check direct path with one-cycle latency.
    load(2'd0, 8'hE8);
    load(2'd1, 8'h96);
    load(2'd2, 8'h80);
    load(2'd3, 8'hFE);
    x = 3'b011;
    tick();
    check("direct x=3", 32'(y), 32'h9);
    x = 3'b111;
    check("direct latency hold", 32'(y), 32'h9);
    tick();
    check("direct x=7", 32'(y), 32'hF);
    x = 3'b100;
    tick();
    check("direct x=4", 32'(y), 32'hA);

    // Sweeps: first, repeat, then with ignored write/start mid-sweep.
    run_sweep(exp_tab, 16'h7144, 1'b0, "sweep1");
    run_sweep(exp_tab, 16'h7144, 1'b0, "sweep2");
    run_sweep(exp_tab, 16'h7144, 1'b1, "sweep_poke");
    x = 3'b001;
    tick();
    check("table a intact", 32'(y), 32'hA);

    // Reset in the middle of a sweep at idx 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midrst idx3", 32'(sweep_idx), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(sweep_valid), 32'd0);
    check("midrst idx", 32'(sweep_idx), 32'd0);
    check("midrst sweep_y", 32'(sweep_y), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ones_cnt", 32'(ones_cnt), 32'd0);
    check("midrst y", 32'(y), 32'd0);
    tick();
    rst_n = 1'b1;
    x = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst no_done[%0d]", i), 32'(done), 32'd0);
    end
    check("midrst tables zero", 32'(y), 32'd0);

    // Sweep with all tables zero.
    run_sweep(exp_zero, 16'h0000, 1'b0, "sweep_zero");

    // Out-of-range select on the N_OUT=5 instance is dropped; a valid one lands.
    cfg_we2 = 1'b1; cfg_sel2 = 3'd5; cfg_data2 = 8'hFF;
    tick();
    cfg_we2 = 1'b0;
    x2 = 3'd7;
    tick();
    check("oor x=7", 32'(y2), 32'h0);
    x2 = 3'd0;
    tick();
    check("oor x=0", 32'(y2), 32'h0);
    cfg_we2 = 1'b1; cfg_sel2 = 3'd4; cfg_data2 = 8'h01;
    tick();
    cfg_we2 = 1'b0;
    tick();
    check("sel4 x=0", 32'(y2), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
